// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control path.
// Contents: FSM state enum (11 states), RV32 opcode constants, ALUOp codes,
// alu_src_b select codes, trap cause codes and a memory-state helper.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_e;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

    // States that hold a request on the unified memory port.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory request.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   wait_i     - a memory state is active and mem_ready is low this cycle
//   timeout_o  - stalled with the count already at TIMEOUT_CYCLES
// The count clears whenever wait_i drops (handshake done or state left).
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic timeout_o
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear when not stalled, saturate at the limit so it never wraps.
    always_comb begin
        count_d = count_q;
        if (!wait_i) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    assign timeout_o = wait_i && (count_q == LIMIT);

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32 core (R, I-ALU, LW, SW, BEQ).
// Inputs : clk, rst (sync, active high), opcode (IR[6:0]), instr_30 (IR[30]),
//          zero (ALU compare flag), mem_ready (memory handshake completion).
// Outputs: memory port control (mem_req, mem_we, iord), PC/IR enables
//          (ir_write, pc_write, pc_branch), regfile write (reg_write,
//          result_src), ALU operand/op selects (alu_src_a, alu_src_b, alu_op,
//          alu_inst30) and trap status (halted, trap_cause).
// Outputs are decoded from the state register; the only input-dependent ones
// are the FETCH completion strobes, pc_branch and alu_inst30.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       instr_30,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_branch,
    output logic       reg_write,
    output logic       result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       alu_inst30,
    output logic       halted,
    output logic [1:0] trap_cause
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] cause_q;
    logic [1:0] cause_d;
    logic       wait_s;
    logic       timeout_s;

    assign wait_s = is_mem_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .wait_i   (wait_s),
        .timeout_o(timeout_s)
    );

    // Next-state, trap cause and output decode for the current state.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_branch  = 1'b0;
        reg_write  = 1'b0;
        result_src = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        alu_inst30 = 1'b0;
        halted     = 1'b0;
        trap_cause = cause_q;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                // mem_ready beats a simultaneous timeout.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = TC_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALUOut <= PC + imm, used as the branch target.
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_R_TYPE: state_d = S_EXEC_R;
                    OP_I_ALU:  state_d = S_EXEC_I;
                    OP_LOAD:   state_d = S_MEM_ADDR;
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = TC_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_FUNCT;
                alu_inst30 = instr_30;
                state_d    = S_WB_ALU;
            end
            S_EXEC_I: begin
                // IR[30] is part of the immediate here, so addi never turns into sub.
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_STORE) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = TC_TIMEOUT;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    cause_d = TC_TIMEOUT;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                pc_branch = zero;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                halted  = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
                cause_d = TC_ILLEGAL;
            end
        endcase

        // Reset is synchronous, but the outputs are forced low for its whole duration.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_branch  = 1'b0;
            reg_write  = 1'b0;
            result_src = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_ADD;
            alu_inst30 = 1'b0;
            halted     = 1'b0;
            trap_cause = TC_NONE;
        end else begin
            trap_cause = cause_q;
        end
    end

    // State and sticky trap cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cause_q <= TC_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm (TIMEOUT_CYCLES = 4).
// A step-queue model predicts the full output vector every cycle; literal
// checks pin latencies and individual fields at hand-computed points.
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 4;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'h7F;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       instr_30;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_branch;
    logic       reg_write, result_src, alu_src_a, alu_inst30, halted;
    logic [1:0] alu_src_b, alu_op, trap_cause;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: queue of remaining instruction steps, F=fetch D=decode R=exec-R
    // I=exec-I A=address L=load access S=store access W=ALU writeback
    // M=load writeback B=branch T=trapped.
    byte        steps[$];
    int         waitc;
    logic [1:0] mcause;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_30(instr_30), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_branch(pc_branch),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .alu_inst30(alu_inst30),
        .halted(halted), .trap_cause(trap_cause)
    );

    // Bits: 16 req,15 we,14 iord,13 irw,12 pcw,11 br,10 rw,9 rsrc,8 srca,
    // 7:6 srcb,5:4 aluop,3 i30,2 halted,1:0 cause
    function automatic logic [16:0] expect_vec(input byte s, input logic rdy,
                                               input logic z, input logic i30,
                                               input logic [1:0] c);
        logic [16:0] v;
        v = 17'd0;
        case (s)
            "F": begin v[16] = 1'b1; v[13] = rdy; v[12] = rdy; v[7:6] = 2'b01; end
            "D": v[7:6] = 2'b10;
            "R": begin v[8] = 1'b1; v[5:4] = 2'b10; v[3] = i30; end
            "I": begin v[8] = 1'b1; v[7:6] = 2'b10; v[5:4] = 2'b10; end
            "A": begin v[8] = 1'b1; v[7:6] = 2'b10; end
            "L": begin v[16] = 1'b1; v[14] = 1'b1; end
            "S": begin v[16] = 1'b1; v[15] = 1'b1; v[14] = 1'b1; end
            "W": v[10] = 1'b1;
            "M": begin v[10] = 1'b1; v[9] = 1'b1; end
            "B": begin v[8] = 1'b1; v[5:4] = 2'b01; v[11] = z; end
            "T": begin v[2] = 1'b1; v[1:0] = c; end
            default: v = 17'h1FFFF;
        endcase
        return v;
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [16:0] act;
            logic [16:0] exp;
            byte cur;
            cur = steps[0];
            act = {mem_req, mem_we, iord, ir_write, pc_write, pc_branch, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, alu_inst30, halted, trap_cause};
            exp = rst ? 17'd0 : expect_vec(cur, mem_ready, zero, instr_30, mcause);
            n_vec++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL cycle step=%c rst=%0b got=%h want=%h t=%0t", cur, rst, act, exp, $time);
            end
            if (rst) begin
                steps = {8'("F")};
                waitc = 0;
                mcause = 2'd0;
            end else begin
                case (cur)
                    "F", "L", "S": begin
                        if (mem_ready) begin
                            waitc = 0;
                            void'(steps.pop_front());
                            if (cur == "F") steps.push_back("D");
                        end else if (waitc == TMO) begin
                            steps = {8'("T")};
                            mcause = 2'd2;
                            waitc = 0;
                        end else begin
                            waitc++;
                        end
                    end
                    "D": begin
                        void'(steps.pop_front());
                        case (opcode)
                            OPC_R:   begin steps.push_back("R"); steps.push_back("W"); end
                            OPC_I:   begin steps.push_back("I"); steps.push_back("W"); end
                            OPC_LW:  begin steps.push_back("A"); steps.push_back("L"); steps.push_back("M"); end
                            OPC_SW:  begin steps.push_back("A"); steps.push_back("S"); end
                            OPC_BEQ: steps.push_back("B");
                            default: begin steps = {8'("T")}; mcause = 2'd1; end
                        endcase
                    end
                    "T": ;
                    default: void'(steps.pop_front());
                endcase
                if (steps.size() == 0) steps.push_back("F");
            end
        end
    end

    task automatic apply(input logic r, input logic rdy, input logic [6:0] opc,
                         input logic i30, input logic z);
        rst = r; mem_ready = rdy; opcode = opc; instr_30 = i30; zero = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        steps = {8'("F")};
        waitc = 0;
        mcause = 2'd0;
        apply(1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
        chk_en = 1'b1;
        #2 lit("rst_mem_req", {1'b0, mem_req}, 2'd0);
        lit("rst_halted", {1'b0, halted}, 2'd0);
        tick(); tick();

        // R-type SUB, zero-wait: 4 cycles
        apply(1'b0, 1'b1, OPC_R, 1'b1, 1'b0);
        #2 lit("sub_f_irw", {1'b0, ir_write}, 2'd1); lit("sub_f_pcw", {1'b0, pc_write}, 2'd1); tick();
        #2 lit("sub_d_srcb", alu_src_b, 2'd2); tick();
        #2 lit("sub_x_aluop", alu_op, 2'd2); lit("sub_x_i30", {1'b0, alu_inst30}, 2'd1); tick();
        #2 lit("sub_w_rw", {1'b0, reg_write}, 2'd1); lit("sub_w_rsrc", {1'b0, result_src}, 2'd0); tick();

        // ADDI with instr_30=1
        apply(1'b0, 1'b1, OPC_I, 1'b1, 1'b0);
        #2 lit("addi_f_req", {1'b0, mem_req}, 2'd1); tick(); tick();
        #2 lit("addi_x_aluop", alu_op, 2'd2); lit("addi_x_i30", {1'b0, alu_inst30}, 2'd0); tick();
        #2 lit("addi_c4_rw", {1'b0, reg_write}, 2'd1); tick();

        // LW with 3 wait cycles in MEM_RD: WB_MEM in cycle 8
        apply(1'b0, 1'b1, OPC_LW, 1'b0, 1'b0); tick(); tick();
        apply(1'b0, 1'b0, OPC_LW, 1'b0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            #2 lit("lw_wait_req", {1'b0, mem_req}, 2'd1); lit("lw_wait_iord", {1'b0, iord}, 2'd1); tick();
        end
        apply(1'b0, 1'b1, OPC_LW, 1'b0, 1'b0); tick();
        #2 lit("lw_c8_rw", {1'b0, reg_write}, 2'd1); lit("lw_c8_rsrc", {1'b0, result_src}, 2'd1); tick();

        // SW with one wait; mem_ready=1 in DECODE is ignored
        apply(1'b0, 1'b1, OPC_SW, 1'b0, 1'b0); tick(); tick();
        apply(1'b0, 1'b0, OPC_SW, 1'b0, 1'b0); tick();
        #2 lit("sw_we", {1'b0, mem_we}, 2'd1); tick();
        apply(1'b0, 1'b1, OPC_SW, 1'b0, 1'b0); tick();

        // BEQ taken then not taken, 3 cycles each
        apply(1'b0, 1'b1, OPC_BEQ, 1'b0, 1'b1); tick(); tick();
        #2 lit("beq_taken", {1'b0, pc_branch}, 2'd1); tick();
        apply(1'b0, 1'b1, OPC_BEQ, 1'b0, 1'b0);
        #2 lit("beq_back_fetch", {1'b0, mem_req}, 2'd1); tick(); tick();
        #2 lit("beq_not_taken", {1'b0, pc_branch}, 2'd0); tick();

        // FETCH timeout: 5 stalled cycles -> TRAP, cause 10
        apply(1'b0, 1'b0, OPC_R, 1'b0, 1'b0);
        repeat (5) tick();
        #2 lit("fto_halted", {1'b0, halted}, 2'd1); lit("fto_cause", trap_cause, 2'd2);
        lit("fto_req", {1'b0, mem_req}, 2'd0); tick();
        apply(1'b1, 1'b0, OPC_R, 1'b0, 1'b0);
        #2 lit("fto_rst_halted", {1'b0, halted}, 2'd0); tick();

        // Same stall, but mem_ready on the 5th cycle completes normally
        apply(1'b0, 1'b0, OPC_BEQ, 1'b0, 1'b0);
        repeat (4) tick();
        apply(1'b0, 1'b1, OPC_BEQ, 1'b0, 1'b0); tick();
        #2 lit("late_rdy_decode", alu_src_b, 2'd2); lit("late_rdy_halted", {1'b0, halted}, 2'd0); tick();
        tick();

        // Illegal opcode -> sticky TRAP, cause 01
        apply(1'b0, 1'b1, OPC_BAD, 1'b0, 1'b0); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'($urandom_range(0, 1)), OPC_BAD, 1'b0, 1'b0);
            #2 lit("ill_req", {1'b0, mem_req}, 2'd0); lit("ill_halted", {1'b0, halted}, 2'd1);
            lit("ill_cause", trap_cause, 2'd1); tick();
        end
        apply(1'b1, 1'b0, OPC_R, 1'b0, 1'b0); tick();
        apply(1'b0, 1'b0, OPC_R, 1'b0, 1'b0);
        #2 lit("ill_rst_halted", {1'b0, halted}, 2'd0); lit("ill_rst_req", {1'b0, mem_req}, 2'd1); tick();

        // LW timing out in MEM_RD
        apply(1'b0, 1'b1, OPC_LW, 1'b0, 1'b0); tick(); tick();
        apply(1'b0, 1'b0, OPC_LW, 1'b0, 1'b0); tick();
        repeat (5) tick();
        #2 lit("lwto_cause", trap_cause, 2'd2); lit("lwto_rw", {1'b0, reg_write}, 2'd0); tick();
        apply(1'b1, 1'b0, OPC_LW, 1'b0, 1'b0); tick();

        // Reset in the middle of a stalled store
        apply(1'b0, 1'b1, OPC_SW, 1'b0, 1'b0); tick(); tick();
        apply(1'b0, 1'b0, OPC_SW, 1'b0, 1'b0); tick();
        #2 lit("swrst_we_before", {1'b0, mem_we}, 2'd1); tick();
        apply(1'b1, 1'b0, OPC_SW, 1'b0, 1'b0);
        #2 lit("swrst_we_during", {1'b0, mem_we}, 2'd0); tick();
        apply(1'b0, 1'b0, OPC_SW, 1'b0, 1'b0);
        #2 lit("swrst_we_after", {1'b0, mem_we}, 2'd0); lit("swrst_fetch", {1'b0, mem_req}, 2'd1); tick();
        apply(1'b0, 1'b1, OPC_R, 1'b0, 1'b0);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
